// File: rtl/hello_merger.sv
// hello_merger: merges two HELLO AXI-Stream packet sources into one stream,
// arbitrating per packet and buffering one beat in a registered output stage.
module hello_merger #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [63:0] S0_AXIS_TDATA,
  input  logic        S0_AXIS_TLAST,
  input  logic [31:0] S0_AXIS_TUSER,
  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  input  logic [63:0] S1_AXIS_TDATA,
  input  logic        S1_AXIS_TLAST,
  input  logic [31:0] S1_AXIS_TUSER,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic [31:0] M_AXIS_TUSER,
  output logic        M_AXIS_TDEST
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        last_grant_r, last_grant_nxt_s;
  logic        out_valid_r;
  logic [63:0] tdata_r;
  logic        tlast_r;
  logic [31:0] tuser_r;
  logic        tdest_r;
  logic        room_s, s0_ready_s, s1_ready_s, acc0_s, acc1_s;

  // The output register can take a beat when empty or draining this cycle.
  assign room_s = ~out_valid_r | M_AXIS_TREADY;
  assign acc0_s = S0_AXIS_TVALID & s0_ready_s;
  assign acc1_s = S1_AXIS_TVALID & s1_ready_s;

  // Arbiter next state, grant memory and slave ready generation
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    s0_ready_s       = 1'b0;
    s1_ready_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
          if ((FIXED_PRIORITY != 32'sd0) || last_grant_r) begin
            state_nxt_s = GRANT0;
          end else begin
            state_nxt_s = GRANT1;
          end
        end else if (S0_AXIS_TVALID) begin
          state_nxt_s = GRANT0;
        end else if (S1_AXIS_TVALID) begin
          state_nxt_s = GRANT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT0: begin
        s0_ready_s = room_s;
        if (S0_AXIS_TVALID && room_s && S0_AXIS_TLAST) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = 1'b0;
        end else begin
          state_nxt_s = GRANT0;
        end
      end
      GRANT1: begin
        s1_ready_s = room_s;
        if (S1_AXIS_TVALID && room_s && S1_AXIS_TLAST) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = 1'b1;
        end else begin
          state_nxt_s = GRANT1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state and last-grant register
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // One-entry output register; a new beat may replace one that drains
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      out_valid_r <= 1'b0;
      tdata_r     <= 64'd0;
      tlast_r     <= 1'b0;
      tuser_r     <= 32'd0;
      tdest_r     <= 1'b0;
    end else if (acc0_s) begin
      out_valid_r <= 1'b1;
      tdata_r     <= S0_AXIS_TDATA;
      tlast_r     <= S0_AXIS_TLAST;
      tuser_r     <= S0_AXIS_TUSER;
      tdest_r     <= 1'b0;
    end else if (acc1_s) begin
      out_valid_r <= 1'b1;
      tdata_r     <= S1_AXIS_TDATA;
      tlast_r     <= S1_AXIS_TLAST;
      tuser_r     <= S1_AXIS_TUSER;
      tdest_r     <= 1'b1;
    end else if (out_valid_r && M_AXIS_TREADY) begin
      out_valid_r <= 1'b0;
    end
  end

  assign S0_AXIS_TREADY = s0_ready_s;
  assign S1_AXIS_TREADY = s1_ready_s;
  assign M_AXIS_TVALID  = out_valid_r;
  assign M_AXIS_TDATA   = tdata_r;
  assign M_AXIS_TLAST   = tlast_r;
  assign M_AXIS_TUSER   = tuser_r;
  assign M_AXIS_TDEST   = tdest_r;

endmodule

// File: tb/tb_hello_merger.sv
// Bench for hello_merger: one instance per priority mode, a cycle table for the
// single-source timing cases, and packet-level reference checks elsewhere.
module tb_hello_merger;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] user;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] user;
    logic        last;
    logic        dest;
  } obs_t;

  typedef struct {
    logic       s0v;
    logic [7:0] d;
    logic       s0l;
    logic       mr;
    logic       e_rdy;
    logic       e_mv;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_valid [2][2];
  logic        s_ready [2][2];
  logic [63:0] s_data  [2][2];
  logic        s_last  [2][2];
  logic [31:0] s_user  [2][2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic [63:0] m_data  [2];
  logic        m_last  [2];
  logic [31:0] m_user  [2];
  logic        m_dest  [2];

  // Instance 0 uses round-robin, instance 1 fixed priority
  for (genvar g = 0; g < 2; g++) begin : g_dut
    hello_merger #(.FIXED_PRIORITY(g)) u_dut (
      .AXIS_ACLK      (clk),
      .AXIS_ARESET    (rst),
      .S0_AXIS_TVALID (s_valid[g][0]),
      .S0_AXIS_TREADY (s_ready[g][0]),
      .S0_AXIS_TDATA  (s_data[g][0]),
      .S0_AXIS_TLAST  (s_last[g][0]),
      .S0_AXIS_TUSER  (s_user[g][0]),
      .S1_AXIS_TVALID (s_valid[g][1]),
      .S1_AXIS_TREADY (s_ready[g][1]),
      .S1_AXIS_TDATA  (s_data[g][1]),
      .S1_AXIS_TLAST  (s_last[g][1]),
      .S1_AXIS_TUSER  (s_user[g][1]),
      .M_AXIS_TVALID  (m_valid[g]),
      .M_AXIS_TREADY  (m_ready[g]),
      .M_AXIS_TDATA   (m_data[g]),
      .M_AXIS_TLAST   (m_last[g]),
      .M_AXIS_TUSER   (m_user[g]),
      .M_AXIS_TDEST   (m_dest[g])
    );
  end

  int    errors = 0;
  int    checks = 0;
  beat_t src_q [2][2][$];
  beat_t exp_q [2][2][$];
  obs_t  obs_q [2][$];
  logic  stall_prev [2];
  obs_t  held [2];
  int    present_pct = 100;
  int    ready_pct = 100;
  vec_t  tbl [17];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t cur_out(int i);
    cur_out = {m_data[i], m_user[i], m_last[i], m_dest[i]};
  endfunction

  // One clock: sample at negedge, then drive sources and sinks after posedge
  task automatic step();
    logic acc [2][2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) acc[i][p] = s_valid[i][p] && s_ready[i][p];
      if (s_valid[i][0] && s_valid[i][1])
        chk("both_ready", 128'(s_ready[i][0] & s_ready[i][1]), 128'd0);
      if (stall_prev[i])
        chk("hold_stable", 128'({m_valid[i], cur_out(i)}), 128'({1'b1, held[i]}));
      stall_prev[i] = m_valid[i] && !m_ready[i];
      held[i] = cur_out(i);
      if (m_valid[i] && m_ready[i]) obs_q[i].push_back(cur_out(i));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[i][p]) void'(src_q[i][p].pop_front());
        if (!(s_valid[i][p] && !acc[i][p])) begin
          if (src_q[i][p].size() > 0 && int'($urandom_range(99, 0)) < present_pct) begin
            s_valid[i][p] = 1'b1;
            {s_data[i][p], s_user[i][p], s_last[i][p]} = src_q[i][p][0];
          end else begin
            s_valid[i][p] = 1'b0;
          end
        end
      end
      m_ready[i] = (int'($urandom_range(99, 0)) < ready_pct);
    end
  endtask

  task automatic run(int max);
    int   n = 0;
    logic busy = 1'b1;
    while (busy && n < max) begin
      step();
      n++;
      busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) busy = 1'b1;
        for (int p = 0; p < 2; p++)
          if (s_valid[i][p] || src_q[i][p].size() > 0) busy = 1'b1;
      end
    end
    chk("drain_busy", 128'(busy), 128'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      obs_q[i].delete();
      stall_prev[i] = 1'b0;
      m_ready[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        src_q[i][p].delete();
        exp_q[i][p].delete();
        s_valid[i][p] = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_pkt(int p, int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.user = $urandom;
      b.last = (k == len - 1);
      for (int i = 0; i < 2; i++) begin
        src_q[i][p].push_back(b);
        exp_q[i][p].push_back(b);
      end
    end
  endtask

  // Packet-level arbitration model for sources that are always valid
  task automatic cmp_ordered(int i, string name);
    int    lastg = 1;
    int    pick;
    int    k = 0;
    beat_t b;
    obs_t  e;
    chk({name, "_count"}, 128'(obs_q[i].size()), 128'(exp_q[i][0].size() + exp_q[i][1].size()));
    while (exp_q[i][0].size() + exp_q[i][1].size() > 0) begin
      if (exp_q[i][0].size() > 0 && exp_q[i][1].size() > 0) pick = (i == 1 || lastg == 1) ? 0 : 1;
      else pick = (exp_q[i][0].size() > 0) ? 0 : 1;
      do begin
        b = exp_q[i][pick].pop_front();
        e = {b, pick[0]};
        if (k < obs_q[i].size()) chk($sformatf("%s_beat%0d", name, k), 128'(obs_q[i][k]), 128'(e));
        k++;
      end while (!b.last);
      lastg = pick;
    end
  endtask

  // Each output beat must be the next one of its source, packets never interleaved
  task automatic cmp_unordered(int i, string name);
    logic  open = 1'b0;
    logic  open_port = 1'b0;
    beat_t b;
    chk({name, "_count"}, 128'(obs_q[i].size()), 128'(exp_q[i][0].size() + exp_q[i][1].size()));
    foreach (obs_q[i][k]) begin
      if (open) chk({name, "_interleave"}, 128'(obs_q[i][k].dest), 128'(open_port));
      if (exp_q[i][obs_q[i][k].dest].size() > 0) begin
        b = exp_q[i][obs_q[i][k].dest].pop_front();
        chk({name, "_beat"}, 128'(obs_q[i][k]), 128'({b, obs_q[i][k].dest}));
      end
      open = !obs_q[i][k].last;
      open_port = obs_q[i][k].dest;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t b2;
    logic  seen;
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0};
    tbl[3]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    for (int k = 8; k < 12; k++) tbl[k] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0};
    tbl[12] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0};
    tbl[13] = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0};
    tbl[14] = '{1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB3, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB4, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b1;
      stall_prev[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        s_valid[i][p] = 1'b1;
        s_data[i][p]  = 64'hFFFF_0000_FFFF_0000;
        s_last[i][p]  = 1'b1;
        s_user[i][p]  = 32'h1234_5678;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mvalid", 128'(m_valid[i]), 128'd0);
      chk("rst_mout", 128'(cur_out(i)), 128'd0);
      chk("rst_sready", 128'({s_ready[i][0], s_ready[i][1]}), 128'd0);
      for (int p = 0; p < 2; p++) s_valid[i][p] = 1'b0;
    end
    rst = 1'b0;

    // Cycle table on instance 0, port 0 only
    for (int k = 0; k < 17; k++) begin
      s_valid[0][0] = tbl[k].s0v;
      s_data[0][0]  = {56'h5A5A_0000_0000_00, tbl[k].d};
      s_user[0][0]  = {24'hE0E0E0, tbl[k].d};
      s_last[0][0]  = tbl[k].s0l;
      m_ready[0]    = tbl[k].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_s0rdy", k), 128'(s_ready[0][0]), 128'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d_s1rdy", k), 128'(s_ready[0][1]), 128'd0);
      chk($sformatf("tbl%0d_mvalid", k), 128'(m_valid[0]), 128'(tbl[k].e_mv));
      if (tbl[k].e_mv)
        chk($sformatf("tbl%0d_out", k), 128'(cur_out(0)),
            128'({56'h5A5A_0000_0000_00, tbl[k].e_d, 24'hE0E0E0, tbl[k].e_d, tbl[k].e_l, 1'b0}));
      @(posedge clk);
      #1;
    end

    // Simultaneous 2-beat packets on both ports
    do_reset();
    push_pkt(0, 2);
    push_pkt(1, 2);
    run(200);
    cmp_ordered(0, "pair_rr");
    cmp_ordered(1, "pair_fp");

    // Back-to-back single-beat packets on both ports
    do_reset();
    for (int j = 0; j < 4; j++) begin
      push_pkt(0, 1);
      push_pkt(1, 1);
    end
    run(200);
    cmp_ordered(0, "single_rr");
    cmp_ordered(1, "single_fp");

    // Reset while beat 2 of a 4-beat packet sits on the output
    do_reset();
    push_pkt(0, 4);
    b2 = src_q[0][0][1];
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = m_valid[0] && (m_data[0] == b2.data);
    end
    chk("midrst_beat2_seen", 128'(m_data[0]), 128'(b2.data));
    rst = 1'b1;
    #1;
    chk("midrst_mvalid0", 128'(m_valid[0]), 128'd0);
    chk("midrst_mvalid1", 128'(m_valid[1]), 128'd0);
    chk("midrst_sready", 128'({s_ready[0][0], s_ready[0][1], s_ready[1][0], s_ready[1][1]}), 128'd0);
    do_reset();
    push_pkt(1, 3);
    run(200);
    cmp_ordered(0, "postrst_rr");
    cmp_ordered(1, "postrst_fp");

    // Random gaps and backpressure
    do_reset();
    present_pct = 60;
    ready_pct = 70;
    for (int j = 0; j < 12; j++) begin
      push_pkt(0, int'($urandom_range(4, 1)));
      push_pkt(1, int'($urandom_range(4, 1)));
    end
    run(4000);
    cmp_unordered(0, "rand_rr");
    cmp_unordered(1, "rand_fp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
